// File: rtl/pc_unit_if.sv
// pc_unit_if: control/status bundle between the decode/control side and the
// program-counter stage.
//   master modport : decode/control side (drives PCWre, pc_src, branch_taken,
//                    imm, rs1_data, halt_req; observes PC, state and counters)
//   slave modport  : pc_unit itself (the reverse directions)
interface pc_unit_if;
  logic        PCWre;
  logic [1:0]  pc_src;
  logic        branch_taken;
  logic [31:0] imm;
  logic [31:0] rs1_data;
  logic        halt_req;
  logic [31:0] curPC;
  logic [31:0] pc_plus4;
  logic        halted;
  logic        fault;
  logic [1:0]  fault_cause;
  logic [31:0] fault_pc;
  logic [31:0] cycle_cnt;
  logic [31:0] instret_cnt;

  modport master (
    output PCWre, pc_src, branch_taken, imm, rs1_data, halt_req,
    input  curPC, pc_plus4, halted, fault, fault_cause, fault_pc,
           cycle_cnt, instret_cnt
  );

  modport slave (
    input  PCWre, pc_src, branch_taken, imm, rs1_data, halt_req,
    output curPC, pc_plus4, halted, fault, fault_cause, fault_pc,
           cycle_cnt, instret_cnt
  );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: program-counter stage feeding instruction memory.
// Holds the PC, selects the next PC (PC+4, branch, JAL, JALR), checks the
// target for misalignment / out-of-range, and runs a RUN/HALT/FAULT state
// machine with run-cycle and retired-instruction counters.
// Ports:
//   CLK    : clock, rising edge
//   Reset  : synchronous active-low reset
//   bus    : pc_unit_if.slave (control inputs, PC/state/counter outputs)
// All outputs are registered except bus.pc_plus4 (curPC + 4).
module pc_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 128
) (
  input  logic       CLK,
  input  logic       Reset,
  pc_unit_if.slave   bus
);

  localparam logic [31:0] IMEM_LIMIT  = 32'(IMEM_WORDS * 4);

  localparam logic [1:0] SRC_SEQ  = 2'b00;
  localparam logic [1:0] SRC_BR   = 2'b01;
  localparam logic [1:0] SRC_JAL  = 2'b10;
  localparam logic [1:0] SRC_JALR = 2'b11;

  localparam logic [1:0] CAUSE_NONE  = 2'b00;
  localparam logic [1:0] CAUSE_ALIGN = 2'b01;
  localparam logic [1:0] CAUSE_RANGE = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HALT  = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  // Classify a fetch target; misalignment wins over out-of-range.
  function automatic logic [1:0] target_cause(input logic [31:0] addr);
    logic [1:0] c;
    if (addr[1:0] != 2'b00) begin
      c = CAUSE_ALIGN;
    end else if (addr >= IMEM_LIMIT) begin
      c = CAUSE_RANGE;
    end else begin
      c = CAUSE_NONE;
    end
    return c;
  endfunction

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] cycle_q, cycle_d;
  logic [31:0] instret_q, instret_d;
  logic [1:0]  fcause_q, fcause_d;
  logic [31:0] fpc_q, fpc_d;

  logic [31:0] seq_tgt_s;
  logic [31:0] rel_tgt_s;
  logic [31:0] jalr_tgt_s;
  logic [31:0] next_pc_s;
  logic [1:0]  next_cause_s;

  // Candidate targets and next-PC select.
  always_comb begin
    seq_tgt_s  = pc_q + 32'd4;
    rel_tgt_s  = pc_q + bus.imm;
    // JALR clears bit 0 only; bit 1 survives and is caught as misaligned.
    jalr_tgt_s = (bus.rs1_data + bus.imm) & 32'hFFFF_FFFE;
    next_pc_s  = seq_tgt_s;
    case (bus.pc_src)
      SRC_SEQ:  next_pc_s = seq_tgt_s;
      SRC_BR:   next_pc_s = bus.branch_taken ? rel_tgt_s : seq_tgt_s;
      SRC_JAL:  next_pc_s = rel_tgt_s;
      SRC_JALR: next_pc_s = jalr_tgt_s;
      default:  next_pc_s = seq_tgt_s;
    endcase
    next_cause_s = target_cause(next_pc_s);
  end

  // Next-state logic: stall > fault > halt > normal advance.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    cycle_d   = cycle_q;
    instret_d = instret_q;
    fcause_d  = fcause_q;
    fpc_d     = fpc_q;
    case (state_q)
      ST_RUN: begin
        cycle_d = cycle_q + 32'd1;
        if (!bus.PCWre) begin
          pc_d = pc_q;
        end else if (next_cause_s != CAUSE_NONE) begin
          // PC stays on the faulting instruction for debug.
          state_d  = ST_FAULT;
          fpc_d    = next_pc_s;
          fcause_d = next_cause_s;
        end else if (bus.halt_req) begin
          // The ECALL/EBREAK itself retires; PC stays on it.
          state_d   = ST_HALT;
          instret_d = instret_q + 32'd1;
        end else begin
          pc_d      = next_pc_s;
          instret_d = instret_q + 32'd1;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_FAULT;
      end
    endcase
  end

  // State, PC, counters and fault capture registers.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q   <= ST_RUN;
      pc_q      <= RESET_PC;
      cycle_q   <= 32'd0;
      instret_q <= 32'd0;
      fcause_q  <= CAUSE_NONE;
      fpc_q     <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
      fcause_q  <= fcause_d;
      fpc_q     <= fpc_d;
    end
  end

  assign bus.curPC       = pc_q;
  assign bus.pc_plus4    = pc_q + 32'd4;
  assign bus.halted      = (state_q == ST_HALT);
  assign bus.fault       = (state_q == ST_FAULT);
  assign bus.fault_cause = fcause_q;
  assign bus.fault_pc    = fpc_q;
  assign bus.cycle_cnt   = cycle_q;
  assign bus.instret_cnt = instret_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: self-checking bench for pc_unit. A behavioural model tracks
// PC, mode, fault info and counters; directed scenarios follow the feature
// list and a randomized phase compares every cycle against the model.
module tb_pc_unit;
  localparam int IMEM_WORDS = 128;

  logic CLK;
  logic Reset;
  pc_unit_if bus ();

  pc_unit #(.RESET_PC(32'h0000_0000), .IMEM_WORDS(IMEM_WORDS)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: mode 0 = run, 1 = halt, 2 = fault.
  int          m_mode;
  logic [31:0] m_pc, m_cyc, m_ret, m_fpc;
  logic [1:0]  m_fcause;

  logic [131:0] dut_vec;
  assign dut_vec = {bus.curPC, bus.halted, bus.fault, bus.fault_cause,
                    bus.fault_pc, bus.cycle_cnt, bus.instret_cnt};

  function automatic logic [131:0] model_vec();
    return {m_pc, (m_mode == 1), (m_mode == 2), m_fcause, m_fpc, m_cyc, m_ret};
  endfunction

  // Predict the state after the coming edge from the current inputs.
  task automatic model_step();
    logic [31:0] t;
    logic [1:0]  c;
    if (!Reset) begin
      m_mode = 0; m_pc = 32'd0; m_cyc = 32'd0; m_ret = 32'd0;
      m_fpc = 32'd0; m_fcause = 2'd0;
      return;
    end
    if (m_mode != 0) return;
    m_cyc = m_cyc + 32'd1;
    if (!bus.PCWre) return;
    case (bus.pc_src)
      2'd0:    t = m_pc + 32'd4;
      2'd1:    t = bus.branch_taken ? m_pc + bus.imm : m_pc + 32'd4;
      2'd2:    t = m_pc + bus.imm;
      default: t = bus.rs1_data + bus.imm - ((bus.rs1_data + bus.imm) % 32'd2);
    endcase
    if (t % 32'd4 != 32'd0)             c = 2'd1;
    else if (t >= IMEM_WORDS * 4)       c = 2'd2;
    else                                c = 2'd0;
    if (c != 2'd0) begin
      m_mode = 2; m_fpc = t; m_fcause = c;
    end else if (bus.halt_req) begin
      m_mode = 1; m_ret = m_ret + 32'd1;
    end else begin
      m_pc = t; m_ret = m_ret + 32'd1;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic we, input logic [1:0] src, input logic bt,
                       input logic [31:0] im, input logic [31:0] rs1,
                       input logic hr);
    bus.PCWre = we; bus.pc_src = src; bus.branch_taken = bt;
    bus.imm = im; bus.rs1_data = rs1; bus.halt_req = hr;
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
  endtask

  task automatic test_reset();
    drive(1'b1, 2'd0, 1'b0, 32'd0, 32'd0, 1'b0);
    do_reset();
    n_checks++;
    if (dut_vec !== {32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected all-zero", dut_vec);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 2'd0, 1'b0, 32'd0, 32'd0, 1'b0);
      tick();
      exp_pc = 32'(i * 4);
      n_checks++;
      if (bus.curPC !== exp_pc || bus.pc_plus4 !== exp_pc + 32'd4) begin
        n_fail++;
        $display("FAIL seq_pc%0d: got pc=%h p4=%h expected pc=%h", i,
                 bus.curPC, bus.pc_plus4, exp_pc);
      end
    end
    n_checks++;
    if (bus.instret_cnt !== 32'd4 || bus.cycle_cnt !== 32'd4) begin
      n_fail++;
      $display("FAIL seq_counters: got ret=%0d cyc=%0d expected 4/4",
               bus.instret_cnt, bus.cycle_cnt);
    end
  endtask

  task automatic test_branch();
    drive(1'b1, 2'd1, 1'b1, -32'sd8, 32'd0, 1'b0);
    tick();
    n_checks++;
    if (bus.curPC !== 32'h08) begin
      n_fail++;
      $display("FAIL branch_taken: got %h expected 00000008", bus.curPC);
    end
    drive(1'b1, 2'd0, 1'b0, 32'd0, 32'd0, 1'b0);
    tick(); tick();
    drive(1'b1, 2'd1, 1'b0, -32'sd8, 32'd0, 1'b0);
    tick();
    n_checks++;
    if (bus.curPC !== 32'h14 || dut_vec !== model_vec()) begin
      n_fail++;
      $display("FAIL branch_not_taken: got %h expected 00000014", bus.curPC);
    end
  endtask

  task automatic test_jalr();
    drive(1'b1, 2'd3, 1'b0, 32'h3, 32'h21, 1'b0);
    tick();
    n_checks++;
    if (bus.curPC !== 32'h24 || bus.fault !== 1'b0) begin
      n_fail++;
      $display("FAIL jalr_bit0: got pc=%h fault=%b expected 00000024/0",
               bus.curPC, bus.fault);
    end
    drive(1'b1, 2'd3, 1'b0, 32'h0, 32'h22, 1'b0);
    tick();
    n_checks++;
    if (bus.fault !== 1'b1 || bus.fault_cause !== 2'b01 ||
        bus.fault_pc !== 32'h22 || bus.curPC !== 32'h24) begin
      n_fail++;
      $display("FAIL jalr_misalign: got f=%b c=%b fpc=%h pc=%h expected 1/01/22/24",
               bus.fault, bus.fault_cause, bus.fault_pc, bus.curPC);
    end
    drive(1'b1, 2'd0, 1'b0, 32'd0, 32'd0, 1'b1);
    tick(); tick();
    n_checks++;
    if (dut_vec !== model_vec()) begin
      n_fail++;
      $display("FAIL fault_frozen: got %h expected %h", dut_vec, model_vec());
    end
  endtask

  task automatic test_jal_range();
    do_reset();
    drive(1'b1, 2'd2, 1'b0, 32'h200, 32'd0, 1'b0);
    tick();
    n_checks++;
    if (bus.fault !== 1'b1 || bus.fault_cause !== 2'b10 ||
        bus.fault_pc !== 32'h200 || bus.curPC !== 32'h0) begin
      n_fail++;
      $display("FAIL jal_range: got f=%b c=%b fpc=%h pc=%h expected 1/10/200/0",
               bus.fault, bus.fault_cause, bus.fault_pc, bus.curPC);
    end
    do_reset();
    drive(1'b1, 2'd2, 1'b0, 32'h200, 32'd0, 1'b1);
    tick();
    n_checks++;
    if (bus.fault !== 1'b1 || bus.halted !== 1'b0 || bus.instret_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL fault_over_halt: got f=%b h=%b ret=%0d expected 1/0/0",
               bus.fault, bus.halted, bus.instret_cnt);
    end
  endtask

  task automatic test_stall_halt();
    do_reset();
    drive(1'b1, 2'd0, 1'b0, 32'd0, 32'd0, 1'b0);
    tick(); tick();
    drive(1'b0, 2'd2, 1'b0, 32'h200, 32'd0, 1'b1);
    tick(); tick(); tick();
    n_checks++;
    if (bus.curPC !== 32'h8 || bus.cycle_cnt !== 32'd5 || bus.instret_cnt !== 32'd2 ||
        bus.halted !== 1'b0 || bus.fault !== 1'b0) begin
      n_fail++;
      $display("FAIL stall: got pc=%h cyc=%0d ret=%0d h=%b f=%b expected 8/5/2/0/0",
               bus.curPC, bus.cycle_cnt, bus.instret_cnt, bus.halted, bus.fault);
    end
    drive(1'b1, 2'd0, 1'b0, 32'd0, 32'd0, 1'b1);
    tick();
    n_checks++;
    if (bus.halted !== 1'b1 || bus.curPC !== 32'h8 || bus.instret_cnt !== 32'd3 ||
        bus.cycle_cnt !== 32'd6) begin
      n_fail++;
      $display("FAIL halt: got h=%b pc=%h ret=%0d cyc=%0d expected 1/8/3/6",
               bus.halted, bus.curPC, bus.instret_cnt, bus.cycle_cnt);
    end
    drive(1'b1, 2'd2, 1'b0, 32'h4, 32'd0, 1'b0);
    tick(); tick(); tick();
    n_checks++;
    if (bus.halted !== 1'b1 || bus.curPC !== 32'h8 || bus.instret_cnt !== 32'd3 ||
        bus.cycle_cnt !== 32'd6) begin
      n_fail++;
      $display("FAIL halt_frozen: got h=%b pc=%h ret=%0d cyc=%0d expected 1/8/3/6",
               bus.halted, bus.curPC, bus.instret_cnt, bus.cycle_cnt);
    end
  endtask

  task automatic test_reset_from_halt_fault();
    drive(1'b1, 2'd3, 1'b1, 32'h7, 32'h33, 1'b1);
    do_reset();
    n_checks++;
    if (dut_vec !== {32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_from_halt: got %h expected all-zero", dut_vec);
    end
    drive(1'b1, 2'd3, 1'b0, 32'h0, 32'h42, 1'b0);
    tick();
    drive(1'b1, 2'd2, 1'b1, 32'h8, 32'h0, 1'b1);
    do_reset();
    n_checks++;
    if (dut_vec !== {32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_from_fault: got %h expected all-zero", dut_vec);
    end
  endtask

  task automatic test_random();
    int stuck;
    logic [31:0] im;
    stuck = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) im = $urandom_range(0, 600);
      else im = 32'(($urandom_range(0, 40) - 20) * 4);
      drive($urandom_range(0, 4) != 0, 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), im, 32'($urandom_range(0, 520)),
            $urandom_range(0, 25) == 0);
      stuck = (m_mode != 0) ? stuck + 1 : 0;
      Reset = !(stuck > 3 || $urandom_range(0, 60) == 0);
      tick();
      n_checks++;
      if (dut_vec !== model_vec() || bus.pc_plus4 !== m_pc + 32'd4) begin
        n_fail++;
        $display("FAIL random_cycle%0d: got %h expected %h", i, dut_vec, model_vec());
      end
    end
    Reset = 1'b1;
  endtask

  initial begin
    Reset = 1'b0;
    drive(1'b0, 2'd0, 1'b0, 32'd0, 32'd0, 1'b0);
    m_mode = 0; m_pc = 32'd0; m_cyc = 32'd0; m_ret = 32'd0;
    m_fpc = 32'd0; m_fcause = 2'd0;
    #2;
    test_reset();
    test_sequential();
    test_branch();
    test_jalr();
    test_jal_range();
    test_stall_halt();
    test_reset_from_halt_fault();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Program-counter stage directly upstream of the instruction memory; drives curPC each cycle.
- Holds the PC register and selects the next PC: sequential, taken branch, JAL or JALR.
- Checks the selected target for misalignment and out-of-range addresses.
- Run/halt/fault state machine plus cycle and retired-instruction counters for bench and debug visibility.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- IMEM_WORDS, 128: instruction memory depth in words. Legal fetch addresses are 0 .. IMEM_WORDS*4-4.

Ports:
- CLK  input  1  system clock; rising edge.
- Reset  input  1  synchronous, active-low reset.
- PCWre  input  1  PC write enable; 0 = stall (PC holds).
- pc_src  input  2  next-PC select: 00 = PC+4, 01 = branch, 10 = JAL, 11 = JALR.
- branch_taken  input  1  branch condition result; used only when pc_src = 01.
- imm  input  32  sign-extended immediate from the decoder.
- rs1_data  input  32  register-file rs1 value; used only for JALR.
- halt_req  input  1  ECALL/EBREAK decoded; requests halt.
- curPC  output  32  registered PC; fetch address for instruction memory.
- pc_plus4  output  32  curPC+4, combinational; link value for JAL/JALR.
- halted  output  1  1 in HALT state.
- fault  output  1  1 in FAULT state.
- fault_cause  output  2  00 = none, 01 = misaligned, 10 = out of range.
- fault_pc  output  32  target address that caused the fault.
- cycle_cnt  output  32  clock cycles spent in RUN.
- instret_cnt  output  32  number of PC updates (retired instructions).

Behaviour:
- Reset (Reset = 0 at a rising edge), regardless of current state or other inputs:
  - curPC = RESET_PC; state = RUN.
  - halted = 0, fault = 0, fault_cause = 00, fault_pc = 0.
  - cycle_cnt = 0, instret_cnt = 0.
- Target computation (combinational, 32-bit, wrap-around, no carry out):
  - seq = curPC+4.
  - br = curPC+imm when branch_taken = 1, else curPC+4.
  - jal = curPC+imm.
  - jalr = (rs1_data+imm) & 32'hFFFF_FFFE.
  - next_pc = target chosen by pc_src.
- Target checks, applied to next_pc:
  - misaligned if next_pc[1:0] != 00. No compressed ISA, so bit 1 set is a fault.
  - out of range if next_pc >= IMEM_WORDS*4.
  - Misaligned takes priority over out of range when both hold.
- Latency: next_pc is combinational from the current-cycle inputs and is registered into curPC on the same rising edge. The instruction memory sees the new PC one cycle after the control decision.
- RUN state, at each rising edge:
  - cycle_cnt increments every cycle.
  - If PCWre = 0: curPC holds, instret_cnt holds, no check is acted on, halt_req is ignored.
  - Else if next_pc is faulty: go to FAULT; curPC holds (still points at the faulting instruction); fault_pc = next_pc; fault_cause set; instret_cnt holds.
  - Else if halt_req = 1: go to HALT; curPC holds at the ECALL/EBREAK address; instret_cnt increments (the halting instruction retires).
  - Else: curPC = next_pc; instret_cnt increments.
- Priority when several events land on the same edge: Reset > stall > fault > halt. A halt_req on an instruction whose target faults goes to FAULT.
- HALT state:
  - Absorbing until reset.
  - curPC, all counters and fault outputs frozen; PCWre, pc_src and halt_req ignored.
- FAULT state:
  - Absorbing until reset.
  - Everything frozen, including fault_pc and fault_cause.
- Counters: 32-bit, wrap FFFF_FFFF -> 0, no saturation.
- Outputs are registered except pc_plus4.

Test Plan:
- Reset then 4 cycles with PCWre=1, pc_src=00 -> curPC = 0,4,8,C,10; instret_cnt = 4; cycle_cnt = 4.
- At curPC=0x10: pc_src=01, imm=-8, branch_taken=1 -> curPC=0x08. Same with branch_taken=0 -> curPC=0x14.
- pc_src=11, rs1_data=0x21, imm=0x3 -> target 0x24 (bit 0 cleared), no fault. With rs1_data=0x22, imm=0 -> FAULT, fault_cause=01, fault_pc=0x22, curPC unchanged.
- pc_src=10, imm=0x200 at curPC=0 (IMEM_WORDS=128) -> FAULT, cause=10, fault_pc=0x200. Same target at the same time as halt_req=1 -> FAULT, not HALT.
- PCWre=0 for 3 cycles at curPC=0x8 -> curPC stays 0x8, cycle_cnt +3, instret_cnt +0. Then halt_req=1 with PCWre=1 -> halted=1, curPC=0x8, instret_cnt +1, frozen afterwards.
- Reset=0 asserted while in HALT and again while in FAULT -> next edge curPC=RESET_PC, state RUN, all counters and fault outputs cleared.
